// File: rtl/hbm_mvm_out_wb_agen_if.sv
// rtl/hbm_mvm_out_wb_agen_if.sv - engine beat stream and single-beat AXI write channels of the writeback stage
interface hbm_mvm_out_wb_agen_if #(
    parameter int AXI_DW = 256,
    parameter int ADDR_W = 32
);
    logic              in_vld;
    logic [AXI_DW-1:0] in_dat;
    logic              in_rdy;
    logic              m_awvalid;
    logic [ADDR_W-1:0] m_awaddr;
    logic              m_awready;
    logic              m_wvalid;
    logic [AXI_DW-1:0] m_wdata;
    logic              m_wlast;
    logic              m_wready;
    logic              m_bvalid;
    logic [1:0]        m_bresp;
    logic              m_bready;

    modport master (
        input  in_vld, in_dat, m_awready, m_wready, m_bvalid, m_bresp,
        output in_rdy, m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wlast, m_bready
    );

    modport slave (
        output in_vld, in_dat, m_awready, m_wready, m_bvalid, m_bresp,
        input  in_rdy, m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wlast, m_bready
    );
endinterface

// File: rtl/hbm_mvm_out_wb_agen.sv
// rtl/hbm_mvm_out_wb_agen.sv - MVM output writeback: address generation, beat buffer, single-beat AXI writes
module hbm_mvm_out_wb_agen #(
    parameter int AXI_DW   = 256,
    parameter int ADDR_W   = 32,
    parameter int CNT_W    = 16,
    parameter int FIFO_DEP = 8,
    parameter int MAX_OUT  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_cfg_base,
    input  logic [ADDR_W-1:0] i_cfg_head_str,
    input  logic [ADDR_W-1:0] i_cfg_surf_str,
    input  logic [ADDR_W-1:0] i_cfg_line_str,
    input  logic [CNT_W-1:0]  i_cfg_n_head,
    input  logic [CNT_W-1:0]  i_cfg_n_cg,
    input  logic [CNT_W-1:0]  i_cfg_n_h,
    input  logic [CNT_W-1:0]  i_cfg_n_w,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    hbm_mvm_out_wb_agen_if.master io_bus
);
    localparam int PW = $clog2(FIFO_DEP);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(AXI_DW / 8);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_head_str, r_surf_str, r_line_str;
    logic [CNT_W-1:0]  r_n_head, r_n_cg, r_n_h, r_n_w;
    logic [CNT_W-1:0]  r_hd, r_cg, r_h, r_w;
    logic [ADDR_W-1:0] r_addr, r_row_base, r_surf_base, r_head_base;
    logic [ADDR_W-1:0] r_mem_addr [FIFO_DEP];
    logic [AXI_DW-1:0] r_mem_dat  [FIFO_DEP];
    logic [PW:0]       r_wr_ptr, r_aw_ptr, r_w_ptr;
    logic [OW-1:0]     r_outst;
    logic              r_busy, r_done, r_err;

    logic [PW:0]       w_aw_lag, w_w_lag, w_occ;
    logic              w_full, w_empty, w_room, w_in_rdy, w_awvalid, w_wvalid;
    logic              w_push, w_aw_hs, w_w_hs, w_b_hs, w_b_dec;
    logic              w_w_end, w_h_end, w_cg_end, w_hd_end, w_last, w_zero;
    logic [ADDR_W-1:0] w_row_nxt, w_surf_nxt, w_head_nxt;

    // An entry stays occupied until the slower of the AW and W readers has passed it.
    assign w_aw_lag  = r_wr_ptr - r_aw_ptr;
    assign w_w_lag   = r_wr_ptr - r_w_ptr;
    assign w_occ     = (w_aw_lag > w_w_lag) ? w_aw_lag : w_w_lag;
    assign w_full    = (w_occ == (PW+1)'(FIFO_DEP));
    assign w_empty   = (r_aw_ptr == r_wr_ptr) && (r_w_ptr == r_wr_ptr);
    assign w_room    = (r_outst < OW'(MAX_OUT));

    assign w_in_rdy  = (r_state == S_RUN) && !w_full && w_room;
    assign w_awvalid = ((r_state == S_RUN) || (r_state == S_DRAIN)) && (r_aw_ptr != r_wr_ptr) && w_room;
    assign w_wvalid  = ((r_state == S_RUN) || (r_state == S_DRAIN)) && (r_w_ptr != r_wr_ptr);

    assign w_push    = io_bus.in_vld && w_in_rdy;
    assign w_aw_hs   = w_awvalid && io_bus.m_awready;
    assign w_w_hs    = w_wvalid && io_bus.m_wready;
    assign w_b_hs    = io_bus.m_bvalid && r_busy;
    assign w_b_dec   = w_b_hs && (r_outst != '0);

    assign w_w_end   = (r_w  == r_n_w    - CNT_W'(1));
    assign w_h_end   = (r_h  == r_n_h    - CNT_W'(1));
    assign w_cg_end  = (r_cg == r_n_cg   - CNT_W'(1));
    assign w_hd_end  = (r_hd == r_n_head - CNT_W'(1));
    assign w_last    = w_w_end && w_h_end && w_cg_end && w_hd_end;
    assign w_zero    = (i_cfg_n_head == '0) || (i_cfg_n_cg == '0) || (i_cfg_n_h == '0) || (i_cfg_n_w == '0);

    assign w_row_nxt  = r_row_base  + r_line_str;
    assign w_surf_nxt = r_surf_base + r_surf_str;
    assign w_head_nxt = r_head_base + r_head_str;

    assign io_bus.in_rdy    = w_in_rdy;
    assign io_bus.m_awvalid = w_awvalid;
    assign io_bus.m_awaddr  = w_awvalid ? r_mem_addr[r_aw_ptr[PW-1:0]] : '0;
    assign io_bus.m_wvalid  = w_wvalid;
    assign io_bus.m_wdata   = w_wvalid ? r_mem_dat[r_w_ptr[PW-1:0]] : '0;
    assign io_bus.m_wlast   = 1'b1;
    assign io_bus.m_bready  = r_busy;
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_err  = r_err;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr[PW-1:0]] <= r_addr;
            r_mem_dat[r_wr_ptr[PW-1:0]]  <= io_bus.in_dat;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_head_str  <= '0;
            r_surf_str  <= '0;
            r_line_str  <= '0;
            r_n_head    <= '0;
            r_n_cg      <= '0;
            r_n_h       <= '0;
            r_n_w       <= '0;
            r_hd        <= '0;
            r_cg        <= '0;
            r_h         <= '0;
            r_w         <= '0;
            r_addr      <= '0;
            r_row_base  <= '0;
            r_surf_base <= '0;
            r_head_base <= '0;
            r_wr_ptr    <= '0;
            r_aw_ptr    <= '0;
            r_w_ptr     <= '0;
            r_outst     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_push)  r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
            if (w_aw_hs) r_aw_ptr <= r_aw_ptr + (PW+1)'(1);
            if (w_w_hs)  r_w_ptr  <= r_w_ptr  + (PW+1)'(1);
            if (w_aw_hs && !w_b_dec)      r_outst <= r_outst + OW'(1);
            else if (!w_aw_hs && w_b_dec) r_outst <= r_outst - OW'(1);
            if (w_b_hs && (io_bus.m_bresp != 2'b00)) r_err <= 1'b1;
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_head_str  <= i_cfg_head_str;
                        r_surf_str  <= i_cfg_surf_str;
                        r_line_str  <= i_cfg_line_str;
                        r_n_head    <= i_cfg_n_head;
                        r_n_cg      <= i_cfg_n_cg;
                        r_n_h       <= i_cfg_n_h;
                        r_n_w       <= i_cfg_n_w;
                        r_hd        <= '0;
                        r_cg        <= '0;
                        r_h         <= '0;
                        r_w         <= '0;
                        r_addr      <= i_cfg_base;
                        r_row_base  <= i_cfg_base;
                        r_surf_base <= i_cfg_base;
                        r_head_base <= i_cfg_base;
                        r_err       <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_zero) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // Each carry reloads the inner running sums from the next-outer one.
                    if (w_push) begin
                        if (!w_w_end) begin
                            r_w    <= r_w + CNT_W'(1);
                            r_addr <= r_addr + STEP;
                        end else begin
                            r_w <= '0;
                            if (!w_h_end) begin
                                r_h        <= r_h + CNT_W'(1);
                                r_row_base <= w_row_nxt;
                                r_addr     <= w_row_nxt;
                            end else begin
                                r_h <= '0;
                                if (!w_cg_end) begin
                                    r_cg        <= r_cg + CNT_W'(1);
                                    r_surf_base <= w_surf_nxt;
                                    r_row_base  <= w_surf_nxt;
                                    r_addr      <= w_surf_nxt;
                                end else begin
                                    r_cg <= '0;
                                    if (!w_hd_end) begin
                                        r_hd        <= r_hd + CNT_W'(1);
                                        r_head_base <= w_head_nxt;
                                        r_surf_base <= w_head_nxt;
                                        r_row_base  <= w_head_nxt;
                                        r_addr      <= w_head_nxt;
                                    end else begin
                                        r_hd    <= '0;
                                        r_state <= S_DRAIN;
                                    end
                                end
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if ((r_outst == '0) && w_empty) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hbm_mvm_out_wb_agen.sv
// tb/tb_hbm_mvm_out_wb_agen.sv - directed bench for the MVM output writeback address generator
module tb_hbm_mvm_out_wb_agen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] cfg_base = '0, cfg_head_str = '0, cfg_surf_str = '0, cfg_line_str = '0;
    logic [15:0] cfg_n_head = '0, cfg_n_cg = '0, cfg_n_h = '0, cfg_n_w = '0;
    logic        busy, done, err;

    hbm_mvm_out_wb_agen_if #(.AXI_DW(256), .ADDR_W(32)) bif ();

    hbm_mvm_out_wb_agen #(.AXI_DW(256), .ADDR_W(32), .CNT_W(16), .FIFO_DEP(8), .MAX_OUT(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_cfg_base(cfg_base), .i_cfg_head_str(cfg_head_str),
        .i_cfg_surf_str(cfg_surf_str), .i_cfg_line_str(cfg_line_str),
        .i_cfg_n_head(cfg_n_head), .i_cfg_n_cg(cfg_n_cg), .i_cfg_n_h(cfg_n_h), .i_cfg_n_w(cfg_n_w),
        .o_busy(busy), .o_done(done), .o_err(err),
        .io_bus(bif)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    int src_n = 0, src_idx = 0, err_beat = -1;
    bit aw_en = 1'b1, w_en = 1'b1, b_en = 1'b1;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, done_cnt = 0, both_cnt = 0, ovr_cnt = 0;
    logic [31:0]  aw_q[$];
    logic [255:0] w_q[$];

    function automatic logic [255:0] beat_dat(input int idx);
        logic [31:0] word;
        word = 32'hC0DE_0000 ^ 32'(idx);
        return {8{word}};
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory-side responder and beat source; decides the next posedge's handshakes at each negedge.
    always @(negedge clk) begin
        bit aw_hs, b_hs;
        if (rst) begin
            bif.in_vld = 1'b0; bif.in_dat = '0;
            bif.m_awready = 1'b0; bif.m_wready = 1'b0;
            bif.m_bvalid = 1'b0; bif.m_bresp = 2'b00;
        end else begin
            bif.in_vld    = (src_idx < src_n);
            bif.in_dat    = bif.in_vld ? beat_dat(src_idx) : '0;
            bif.m_awready = aw_en;
            bif.m_wready  = w_en;
            bif.m_bvalid  = b_en && (aw_cnt > b_cnt);
            bif.m_bresp   = (bif.m_bvalid && (b_cnt == err_beat)) ? 2'b10 : 2'b00;
            if (bif.in_vld && bif.in_rdy) src_idx++;
            if (bif.m_awvalid && ((aw_cnt - b_cnt) >= 16)) ovr_cnt++;
            aw_hs = bif.m_awvalid && bif.m_awready;
            b_hs  = bif.m_bvalid && bif.m_bready;
            if (aw_hs) begin aw_q.push_back(bif.m_awaddr); aw_cnt++; end
            if (bif.m_wvalid && bif.m_wready) begin w_q.push_back(bif.m_wdata); w_cnt++; end
            if (aw_hs && b_hs) both_cnt++;
            if (b_hs) b_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_model();
        src_n = 0; src_idx = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; done_cnt = 0; both_cnt = 0; ovr_cnt = 0;
        aw_q.delete(); w_q.delete();
    endtask

    task automatic start_job(input logic [31:0] base, input logic [31:0] hs, input logic [31:0] ss,
                             input logic [31:0] ls, input int nhd, input int ncg, input int nh,
                             input int nw, input int beats);
        clear_model();
        cfg_base = base; cfg_head_str = hs; cfg_surf_str = ss; cfg_line_str = ls;
        cfg_n_head = 16'(nhd); cfg_n_cg = 16'(ncg); cfg_n_h = 16'(nh); cfg_n_w = 16'(nw);
        src_n = beats;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c;
        c = 0;
        while ((done_cnt == 0) && (c < budget)) begin
            tick();
            c++;
        end
        repeat (4) tick();
        check({tag, "_done_pulses"}, 256'(done_cnt), 256'(1));
    endtask

    task automatic check_linear(input string tag, input logic [31:0] base, input int n);
        check({tag, "_aw_cnt"}, 256'(aw_q.size()), 256'(n));
        check({tag, "_w_cnt"}, 256'(w_q.size()), 256'(n));
        check({tag, "_b_cnt"}, 256'(b_cnt), 256'(n));
        for (int i = 0; i < n && i < aw_q.size() && i < w_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 256'(aw_q[i]), 256'(base + 32'(i) * 32'd32));
            check($sformatf("%s_data%0d", tag, i), w_q[i], beat_dat(i));
        end
    endtask

    logic [31:0] t2_exp [12] = '{32'h000, 32'h020, 32'h040, 32'h100, 32'h120, 32'h140,
                                 32'h1000, 32'h1020, 32'h1040, 32'h1100, 32'h1120, 32'h1140};

    initial begin
        int c;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_outputs", 256'({bif.in_rdy, bif.m_awvalid, bif.m_wvalid, bif.m_bready, busy, done, err}), 256'(0));
        check("rst_awaddr", 256'(bif.m_awaddr), 256'(0));
        check("rst_wdata", bif.m_wdata, 256'(0));

        // 1: four heads of 49 tokens, contiguous addresses
        start_job(32'h0800_0000, 32'd1568, 32'd0, 32'd1568, 4, 1, 1, 49, 196);
        check("t1_busy", 256'(busy), 256'(1));
        wait_done("t1", 2000);
        check_linear("t1", 32'h0800_0000, 196);
        check("t1_idle", 256'(busy), 256'(0));

        // 2: CH-group and row carries
        start_job(32'h0, 32'h10000, 32'h1000, 32'h100, 1, 2, 2, 3, 12);
        wait_done("t2", 500);
        check("t2_aw_cnt", 256'(aw_q.size()), 256'(12));
        for (int i = 0; i < 12 && i < aw_q.size(); i++)
            check($sformatf("t2_addr%0d", i), 256'(aw_q[i]), 256'(t2_exp[i]));

        // 3: AW blocked, W drains until the buffer is full
        aw_en = 1'b0;
        start_job(32'h0002_0000, 32'h0, 32'h0, 32'h0, 1, 1, 1, 12, 12);
        repeat (30) tick();
        check("t3_w_cnt", 256'(w_cnt), 256'(8));
        check("t3_aw_cnt", 256'(aw_cnt), 256'(0));
        check("t3_accepted", 256'(src_idx), 256'(8));
        check("t3_in_rdy", 256'(bif.in_rdy), 256'(0));
        aw_en = 1'b1;
        wait_done("t3", 500);
        check_linear("t3", 32'h0002_0000, 12);

        // 4: B held off, outstanding cap
        b_en = 1'b0;
        start_job(32'h0003_0000, 32'h0, 32'h0, 32'h0, 1, 1, 1, 40, 40);
        repeat (60) tick();
        check("t4_aw_cap", 256'(aw_cnt), 256'(16));
        check("t4_in_rdy", 256'(bif.in_rdy), 256'(0));
        check("t4_awvalid", 256'(bif.m_awvalid), 256'(0));
        b_en = 1'b1;
        wait_done("t4", 1000);
        check_linear("t4", 32'h0003_0000, 40);
        check("t4_aw_b_same_cycle", 256'(both_cnt > 0), 256'(1));
        check("t4_over_cap", 256'(ovr_cnt), 256'(0));

        // 5: error response on beat 5
        err_beat = 5;
        start_job(32'h0004_0000, 32'h0, 32'h0, 32'h0, 1, 1, 1, 8, 8);
        wait_done("t5", 500);
        check("t5_err", 256'(err), 256'(1));
        repeat (3) tick();
        check("t5_err_sticky", 256'(err), 256'(1));
        err_beat = -1;

        // 6a: empty job, also clears err
        start_job(32'h0005_0000, 32'h0, 32'h0, 32'h0, 1, 1, 1, 0, 0);
        check("t6_zero_done", 256'(done), 256'(1));
        check("t6_err_clr", 256'(err), 256'(0));
        tick();
        check("t6_zero_end", 256'({done, busy}), 256'(0));
        repeat (3) tick();
        check("t6_zero_traffic", 256'(aw_cnt + w_cnt), 256'(0));
        check("t6_zero_pulses", 256'(done_cnt), 256'(1));

        // 6b: reset mid-run
        start_job(32'h0006_0000, 32'h0, 32'h0, 32'h0, 1, 1, 1, 40, 40);
        c = 0;
        while ((src_idx < 10) && (c < 200)) begin tick(); c++; end
        check("t6_reached10", 256'(src_idx >= 10), 256'(1));
        #1 rst = 1'b1;
        #1;
        check("t6_rst_outputs", 256'({bif.in_rdy, bif.m_awvalid, bif.m_wvalid, bif.m_bready, busy, done, err}), 256'(0));
        tick();
        check("t6_rst_hold", 256'({bif.in_rdy, bif.m_awvalid, bif.m_wvalid, busy}), 256'(0));
        rst = 1'b0;
        clear_model();
        tick();

        // 6c: clean run after reset
        start_job(32'h0007_0000, 32'h0, 32'h0, 32'h0, 1, 1, 1, 20, 20);
        wait_done("t6c", 500);
        check_linear("t6c", 32'h0007_0000, 20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
